ff_capture_scan: RTL and testbench

Serial capture/readback stage that sits directly downstream of a bank of DFF/TFF-family register cells. On request it snapshots their `Q` outputs in parallel, then shifts the snapshot out LSB-first over a valid/ready serial handshake, with an optional even-parity trailer bit. It is the debug/readback path for register state in CPLD designs built from the cell library. It is composed only of clocked logic on one clock.

---
 rtl/ff_capture_scan.sv | 90 +++++++++
 tb/tb_ff_capture_scan.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ff_capture_scan.sv
// Parallel snapshot of register-cell Q outputs, replayed LSB-first over a
// valid/ready serial link with an optional even-parity trailer beat.
module ff_capture_scan #(
  parameter int WIDTH  = 16,
  parameter int PARITY = 1
) (
  input  logic             CLK,
  input  logic             ARN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             CLR,
  input  logic             SRDY,
  output logic             SO,
  output logic             SV,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + PARITY - 1);
  localparam bit HAS_PARITY = (PARITY != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             p_reg, p_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  always_ff @(posedge CLK or negedge ARN) begin
    if (!ARN) begin
      state_reg <= ST_IDLE;
      sr_reg    <= '0;
      p_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START && !CLR) begin
          sr_next    = D;
          p_next     = ^D;
          cnt_next   = CNT_LOAD;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (SRDY) begin
          if (cnt_reg != '0) begin
            sr_next  = sr_reg >> 1;
            cnt_next = cnt_reg - CW'(1);
          end else begin
            state_next = ST_FIN;
          end
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle capture request.
    if (CLR) begin
      state_next = ST_IDLE;
    end
  end

  // The final beat carries parity when enabled; all other beats carry SR[0].
  logic parity_beat;
  assign parity_beat = HAS_PARITY && (cnt_reg == '0);

  assign SV   = (state_reg == ST_SHIFT);
  assign BUSY = (state_reg == ST_SHIFT);
  assign DONE = (state_reg == ST_FIN);
  assign SO   = SV & (parity_beat ? p_reg : sr_reg[0]);

endmodule

// File: tb/tb_ff_capture_scan.sv
// Randomized and directed checking of ff_capture_scan (WIDTH=8, PARITY=1)
// against a frame-queue reference model.
module tb_ff_capture_scan;
  localparam int WIDTH  = 8;
  localparam int PARITY = 1;

  logic             CLK = 1'b0;
  logic             ARN;
  logic [WIDTH-1:0] D;
  logic             START, CLR, SRDY;
  logic             SO, SV, BUSY, DONE;

  always #5 CLK = ~CLK;

  ff_capture_scan #(.WIDTH(WIDTH), .PARITY(PARITY)) dut (
    .CLK(CLK), .ARN(ARN), .D(D), .START(START), .CLR(CLR), .SRDY(SRDY),
    .SO(SO), .SV(SV), .BUSY(BUSY), .DONE(DONE)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame still to be sent, as a queue of bits.
  bit m_active, m_done;
  bit m_bits[$];

  // Observations from the last falling edge, plus frame receiver.
  bit obs_sv, obs_so;
  bit rx_bits[$];
  int sv_cycles, done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_load(input logic [WIDTH-1:0] d);
    m_bits.delete();
    for (int i = 0; i < WIDTH; i++) m_bits.push_back(d[i]);
    if (PARITY != 0) m_bits.push_back(^d);
    m_active = 1'b1;
  endtask

  // Apply one rising edge to the model using the inputs held across it.
  task automatic model_edge();
    if (ARN && obs_sv && SRDY) rx_bits.push_back(obs_so);
    if (!ARN) model_reset();
    else if (CLR) model_reset();
    else if (m_done) m_done = 1'b0;
    else if (m_active) begin
      if (SRDY) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (START) model_load(D);
  endtask

  task automatic compare_outputs();
    bit exp_so;
    exp_so = (m_active && m_bits.size() > 0) ? m_bits[0] : 1'b0;
    check("SV", 32'(SV), 32'(m_active));
    check("BUSY", 32'(BUSY), 32'(m_active));
    check("DONE", 32'(DONE), 32'(m_done));
    check("SO", 32'(SO), 32'(exp_so));
    obs_sv = SV;
    obs_so = SO;
    if (SV) sv_cycles++;
    if (DONE) done_seen++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_outputs();
  endtask

  // Capture d, optionally stall and/or poke D/START mid-frame, then check
  // the received bits and frame length against fixed expectations.
  task automatic run_frame(input logic [WIDTH-1:0] d, input logic [31:0] exp_word,
                           input int exp_len, input int stall_after, input int stall_len,
                           input bit poke);
    logic [31:0] w;
    int stalled;
    bit finished;
    rx_bits.delete();
    sv_cycles = 0;
    done_seen = 0;
    stalled   = 0;
    finished  = 0;
    SRDY  = 1'b1;
    D     = d;
    START = 1'b1;
    tick();
    START = 1'b0;
    if (poke) begin
      D     = '1;
      START = 1'b1;
      tick();
      START = 1'b0;
    end
    for (int c = 0; c < 40 && !finished; c++) begin
      if (rx_bits.size() == stall_after && stalled < stall_len) begin
        SRDY = 1'b0;
        stalled++;
      end else SRDY = 1'b1;
      tick();
      if (done_seen != 0) finished = 1;
    end
    check("frame_timeout", 32'(finished), 32'd1);
    w = '0;
    for (int i = 0; i < rx_bits.size() && i < 32; i++) w[i] = rx_bits[i];
    check("frame_bits", w, exp_word);
    check("frame_nbits", 32'(rx_bits.size()), 32'(WIDTH + PARITY));
    check("frame_len", 32'(sv_cycles), 32'(exp_len));
    SRDY = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("no_second_frame", 32'(sv_cycles), 32'(exp_len));
  endtask

  initial begin
    ARN = 1'b0; START = 1'b1; CLR = 1'b0; SRDY = 1'b1; D = 8'hA5;
    obs_sv = 0; obs_so = 0; sv_cycles = 0; done_seen = 0;
    model_reset();

    // Reset held with START high: nothing may happen.
    #2;
    compare_outputs();
    for (int i = 0; i < 3; i++) tick();
    ARN = 1'b1;
    START = 1'b0;
    tick();

    run_frame(8'hA5, 32'h0A5, 9, -1, 0, 1'b0);
    $display("frame D=a5 rx_bits=%0d sv_cycles=%0d", rx_bits.size(), sv_cycles);
    run_frame(8'h07, 32'h107, 9, -1, 0, 1'b0);
    $display("frame D=07 rx_bits=%0d sv_cycles=%0d", rx_bits.size(), sv_cycles);
    run_frame(8'h3C, 32'h03C, 12, 2, 3, 1'b0);
    $display("frame D=3c backpressure sv_cycles=%0d", sv_cycles);
    run_frame(8'h00, 32'h000, 9, -1, 0, 1'b1);
    $display("frame D=00 with D/START poke sv_cycles=%0d", sv_cycles);

    // Abort after three accepted beats.
    done_seen = 0;
    D = 8'h5A; START = 1'b1; tick(); START = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("abort_sv", 32'(SV), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_done", 32'(done_seen), 32'd0);
    CLR = 1'b1; START = 1'b1; tick();
    CLR = 1'b0; START = 1'b0;
    check("clr_start_idle", 32'(SV), 32'd0);
    tick();
    $display("abort sequence done_seen=%0d", done_seen);

    // Asynchronous reset between edges partway through a frame.
    D = 8'hC3; START = 1'b1; tick(); START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 ARN = 1'b0;
    model_reset();
    #1 compare_outputs();
    check("arst_sv_now", 32'(SV), 32'd0);
    tick();
    #2 ARN = 1'b1;
    tick();
    run_frame(8'h81, 32'h081, 9, -1, 0, 1'b0);
    $display("post-reset frame D=81 sv_cycles=%0d", sv_cycles);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      START = ($urandom_range(0, 3) == 0);
      CLR   = ($urandom_range(0, 24) == 0);
      SRDY  = ($urandom_range(0, 2) != 0);
      D     = WIDTH'($urandom);
      tick();
    end
    START = 1'b0; CLR = 1'b0; SRDY = 1'b1;
    $display("random phase complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
